// File: rtl/sipo_load_ctrl.sv
// Round-robin controller sharing one SIPO shift-register chain between two requesters.
// Words are serialized MSB first, one bit per TICK_DIV clk cycles, then latched.
module sipo_load_ctrl #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 33554432
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sr_data,
    output logic             sr_shift,
    output logic             sr_latch,
    output logic             busy,
    output logic             grant_id
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t           state_reg, state_next;
    logic             rr_reg, rr_next;
    logic             grant_reg, grant_next;
    logic [TW-1:0]    tick_reg, tick_next;
    logic [BW-1:0]    bit_reg, bit_next;
    logic [WIDTH-1:0] buf_reg, buf_next;
    logic             sdata_reg;

    logic [1:0] valid;
    logic [1:0] ready;
    logic       winner;
    logic       accept;
    logic       tick_hit;

    assign valid = {req1_valid, req0_valid};

    // With both requesting the pointer decides; otherwise the lone requester wins.
    assign winner = (&valid) ? rr_reg : req1_valid;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready[gi] = (state_reg == IDLE) && valid[gi] && (winner == 1'(gi));
        end
    endgenerate

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign accept     = |ready;

    assign tick_hit = (state_reg == SHIFT) && (tick_reg == TICK_LAST);
    assign sr_shift = tick_hit;
    // Serial line presents the MSB with the enable and otherwise holds its last bit.
    assign sr_data  = tick_hit ? buf_reg[WIDTH-1] : sdata_reg;
    assign sr_latch = (state_reg == LATCH);
    assign busy     = (state_reg != IDLE);
    assign grant_id = grant_reg;

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        grant_next = grant_reg;
        tick_next  = tick_reg;
        bit_next   = bit_reg;
        buf_next   = buf_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    buf_next   = winner ? req1_data : req0_data;
                    grant_next = winner;
                    rr_next    = ~winner;
                    tick_next  = '0;
                    bit_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (tick_hit) begin
                    tick_next = '0;
                    buf_next  = buf_reg << 1;
                    bit_next  = bit_reg + BW'(1);
                    if (bit_reg == BIT_LAST) begin
                        state_next = LATCH;
                    end
                end else begin
                    tick_next = tick_reg + TW'(1);
                end
            end
            LATCH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            grant_reg <= 1'b0;
            tick_reg  <= '0;
            bit_reg   <= '0;
            buf_reg   <= '0;
            sdata_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
            grant_reg <= grant_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            buf_reg   <= buf_next;
            sdata_reg <= sr_data;
        end
    end

endmodule

// File: tb/tb_sipo_load_ctrl.sv
// Self-checking bench for sipo_load_ctrl: directed scenarios plus random traffic
// compared every cycle against a transfer-level timing model.
module tb_sipo_load_ctrl;

    localparam int W  = 4;
    localparam int TD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic [W-1:0] req0_data  = '0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [W-1:0] req1_data  = '0;
    logic         req1_ready;
    logic         sr_data;
    logic         sr_shift;
    logic         sr_latch;
    logic         busy;
    logic         grant_id;

    sipo_load_ctrl #(.WIDTH(W), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .sr_data    (sr_data),
        .sr_shift   (sr_shift),
        .sr_latch   (sr_latch),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: m_n counts cycles since the accept edge (0 = idle), so shift k falls at
    // m_n == k*TD and the latch at m_n == W*TD+1.
    int           m_n     = 0;
    logic [W-1:0] m_word  = '0;
    logic         m_rr    = 1'b0;
    logic         m_grant = 1'b0;
    logic         m_sdata = 1'b0;
    logic [W-1:0] chain   = '0;
    int           latches = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Check at the falling edge, advance the model, then move to just past the rising edge.
    task automatic cycle();
        logic idle, win, e_r0, e_r1, e_shift, e_sd, e_latch;
        int   k;
        @(negedge clk);
        idle    = (m_n == 0);
        win     = (req0_valid && req1_valid) ? m_rr : req1_valid;
        e_r0    = idle && req0_valid && !win;
        e_r1    = idle && req1_valid && win;
        e_shift = (m_n > 0) && (m_n <= W * TD) && (m_n % TD == 0);
        k       = m_n / TD;
        e_sd    = e_shift ? m_word[W-k] : m_sdata;
        e_latch = (m_n == W * TD + 1);

        check("req0_ready", req0_ready, e_r0);
        check("req1_ready", req1_ready, e_r1);
        check("sr_shift", sr_shift, e_shift);
        check("sr_data", sr_data, e_sd);
        check("sr_latch", sr_latch, e_latch);
        check("busy", busy, m_n != 0);
        check("grant_id", grant_id, m_grant);
        if (e_latch) begin
            check("chain_word", chain, m_word);
            latches++;
            $display("latch word=%0h grant=%0d chain=%0h", m_word, m_grant, chain);
        end
        if (sr_shift) chain = {chain[W-2:0], sr_data};

        if (rst) begin
            m_n = 0; m_rr = 1'b0; m_grant = 1'b0; m_sdata = 1'b0;
        end else if (e_r0 || e_r1) begin
            m_n     = 1;
            m_word  = win ? req1_data : req0_data;
            m_grant = win;
            m_rr    = ~win;
            $display("accept req%0d data=%0h", win, m_word);
        end else if (m_n > 0) begin
            if (e_shift) m_sdata = e_sd;
            m_n = e_latch ? 0 : m_n + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        @(posedge clk);
        #1;
        run(2);
        rst = 1'b0;
        run(1);

        // 1: single word from requester 0
        req0_valid = 1'b1; req0_data = 4'b1011;
        cycle();
        req0_valid = 1'b0;
        run(22);

        // 2: both held, grants alternate
        req0_valid = 1'b1; req0_data = 4'hA;
        req1_valid = 1'b1; req1_data = 4'h5;
        run(4 * (W * TD + 2) + 2);
        req0_valid = 1'b0; req1_valid = 1'b0;
        run(20);

        // 3: lone requester 1 served back-to-back
        req1_valid = 1'b1; req1_data = 4'h3;
        run(3 * (W * TD + 2));
        req1_valid = 1'b0;
        run(20);

        // 4: reset after the second shift aborts the transfer
        req0_valid = 1'b1; req0_data = 4'hF;
        cycle();
        req0_valid = 1'b0;
        for (int i = 0; i < 50 && m_n != 2 * TD + 1; i++) cycle();
        check("abort_point", m_n, 2 * TD + 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_sr_data", sr_data, 1'b0);
        run(6);
        req0_valid = 1'b1; req0_data = 4'h6;
        cycle();
        req0_valid = 1'b0;
        run(20);

        // 5: data change after accept is ignored
        req0_valid = 1'b1; req0_data = 4'hC;
        cycle();
        req0_data = 4'h0;
        run(20);
        req0_valid = 1'b0;
        run(2);

        // 6: requests raised mid-transfer wait for IDLE
        req0_valid = 1'b1; req0_data = 4'h9;
        cycle();
        req0_valid = 1'b0;
        run(5);
        req0_valid = 1'b1; req0_data = 4'h2;
        req1_valid = 1'b1; req1_data = 4'hE;
        run(40);
        req0_valid = 1'b0; req1_valid = 1'b0;
        run(20);

        // Random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_data  = W'($urandom);
            req1_data  = W'($urandom);
            rst        = ($urandom_range(0, 79) == 0);
            cycle();
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        run(24);

        check("latch_seen", latches > 10, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipo_load_ctrl.md
Name: sipo_load_ctrl

Overview:
- Controller that shares one WIDTH-bit serial-in/parallel-out shift register chain between two requesters.
- Arbitrates round-robin between the requesters and captures the winner's parallel word.
- Serializes the word MSB first into the chain, one bit per divided-clock tick, then pulses a latch strobe.
- Sits between board-level pattern sources and the LED SIPO chain, replacing free-running divider clocking with a single-clock enable scheme.

Parameters:
- WIDTH, 4: word width, equal to the number of SIPO stages.
- TICK_DIV, 33554432: clk cycles between successive shift enables. Must be ≥2. Benches override it to 4.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle (valid&ready).
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  WIDTH  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- sr_data  out  1  serial bit into the first SIPO stage.
- sr_shift  out  1  one-cycle shift enable for the chain.
- sr_latch  out  1  one-cycle strobe: chain now holds the complete word.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  1  index of the most recently granted requester.

Behaviour:
- Reset values (clk edge with rst=1):
  - state=IDLE; rr_ptr=0, so requester 0 has priority.
  - tick counter=0; bit counter=0; shift buffer=0.
  - sr_data=0, sr_shift=0, sr_latch=0, busy=0, grant_id=0.
  - rst has priority over all events. Reset during SHIFT or LATCH aborts the transfer: no further sr_shift, and no sr_latch.
- States: IDLE -> SHIFT -> LATCH -> IDLE.
- IDLE, arbitration (combinational ready):
  - Only one valid: that requester wins.
  - Both valid: the requester indexed by rr_ptr wins.
  - reqN_ready=1 only for the winner, only in IDLE. Ready is 0 in every other state.
- On accept (valid&ready at a clk edge):
  - capture the winner's data into the shift buffer;
  - grant_id = winner; rr_ptr = ~winner;
  - tick counter = 0, bit counter = 0; go to SHIFT.
  - rr_ptr updates only on grants, so a lone requester is served back-to-back.
- SHIFT:
  - The tick counter increments each cycle. When it reaches TICK_DIV-1, in that cycle:
    - sr_shift=1 and sr_data = shift buffer MSB (combinationally valid with sr_shift);
    - at the edge, the buffer shifts left by 1, the bit counter increments, and the tick counter clears.
  - After the WIDTH-th shift, go to LATCH.
  - sr_data holds its last value when sr_shift=0.
- Timing, with the accept edge as cycle 0: shift k (k=1..WIDTH) is asserted in cycle k*TICK_DIV-1 relative to the first SHIFT cycle.
- LATCH: sr_latch=1 for exactly one cycle, then IDLE. A new accept is possible in the first IDLE cycle.
- Data order: req data bit WIDTH-1 is shifted first, so after the latch chain stage i holds data bit i (stage 0 = first stage).
- Requester data and valid may change after acceptance without effect on the transfer in progress.
- sr_shift and sr_latch are never high in the same cycle. sr_shift never asserts outside SHIFT.

Test Plan (WIDTH=4, TICK_DIV=4):
1. Reset, then req0_valid=1, req0_data=4'b1011 -> req0_ready pulses one cycle; sr_shift pulses every 4 cycles with sr_data 1,0,1,1; sr_latch pulses once after the 4th shift; modelled 4-stage chain reads 1011; grant_id=0; busy low afterward.
2. Both valid from reset, req0=4'hA, req1=4'h5, held -> grants alternate 0,1,0,1; latched words A,5,A,5; never two consecutive grants to the same requester.
3. Only req1_valid held with 4'h3 -> req1 granted every transfer, back-to-back; req0_ready stays 0; gap of one IDLE cycle between sr_latch and the next accept.
4. Assert rst after the 2nd sr_shift of word 4'hF -> next cycle all outputs 0 and state IDLE; no sr_latch; the following transfer of 4'h6 latches 0110 correctly.
5. req0_data changed to 4'h0 one cycle after accept of 4'hC -> serialized bits are 1,1,0,0; the change is ignored.
6. Requester valid asserted during SHIFT -> ready stays 0 until IDLE; accepted on the first IDLE cycle with the correct round-robin choice.
